// File: rtl/rx_chain_multi_model.sv
// Multi-channel RX chain: per-channel boxcar decimation of DDS I/Q samples by a shared
// programmable rate, buffered in a show-ahead FIFO and presented as AXI-stream with overflow reporting.
module rx_chain_multi_model #(
  parameter int NCH          = 2,
  parameter int IN_WIDTH     = 16,
  parameter int ACC_WIDTH    = 32,
  parameter int RATE_WIDTH   = 12,
  parameter int DEFAULT_RATE = 10,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [15:0]                 rate_axis_tdata_i,
  input  logic                        rate_axis_tvalid_i,
  input  logic [NCH*2*IN_WIDTH-1:0]   dds_iq_axis_tdata_i,
  input  logic [NCH-1:0]              dds_iq_axis_tvalid_i,
  input  logic [NCH-1:0]              axis_tready_i,
  output logic [NCH*2*ACC_WIDTH-1:0]  axis_tdata_o,
  output logic [NCH-1:0]              axis_tvalid_o,
  output logic [NCH-1:0]              overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = 2 * IN_WIDTH;
  localparam int DW = 2 * ACC_WIDTH;

  logic [RATE_WIDTH-1:0] rate_q;
  logic [RATE_WIDTH-1:0] rate_eff;
  logic [RATE_WIDTH-1:0] rate_last;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; combinational blocks use blocking assignments with defaults first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_q <= RATE_WIDTH'(DEFAULT_RATE);
    end else if (rate_axis_tvalid_i) begin
      rate_q <= rate_axis_tdata_i[RATE_WIDTH-1:0];
    end
  end

  // A programmed rate of zero behaves as no decimation at all.
  assign rate_eff  = (rate_q == '0) ? RATE_WIDTH'(1) : rate_q;
  assign rate_last = rate_eff - RATE_WIDTH'(1);

  if (RATE_WIDTH < 16) begin : g_unused_rate
    logic unused_rate_bits;
    assign unused_rate_bits = ^rate_axis_tdata_i[15:RATE_WIDTH];
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [IN_WIDTH-1:0]   s_i, s_q;
    logic [ACC_WIDTH-1:0]  sum_i, sum_q;
    logic [ACC_WIDTH-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic [RATE_WIDTH-1:0] cnt_q, cnt_d;
    logic                  push_req;

    assign s_i   = dds_iq_axis_tdata_i[c*SW +: IN_WIDTH];
    assign s_q   = dds_iq_axis_tdata_i[c*SW+IN_WIDTH +: IN_WIDTH];
    assign sum_i = acc_i_q + {{(ACC_WIDTH-IN_WIDTH){s_i[IN_WIDTH-1]}}, s_i};
    assign sum_q = acc_q_q + {{(ACC_WIDTH-IN_WIDTH){s_q[IN_WIDTH-1]}}, s_q};

    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    always_comb begin
      acc_i_d  = acc_i_q;
      acc_q_d  = acc_q_q;
      cnt_d    = cnt_q;
      push_req = 1'b0;
      if (rate_axis_tvalid_i) begin
        acc_i_d = '0;
        acc_q_d = '0;
        cnt_d   = '0;
      end else if (dds_iq_axis_tvalid_i[c]) begin
        if (cnt_q == rate_last) begin
          push_req = 1'b1;
          acc_i_d  = '0;
          acc_q_d  = '0;
          cnt_d    = '0;
        end else begin
          acc_i_d = sum_i;
          acc_q_d = sum_q;
          cnt_d   = cnt_q + RATE_WIDTH'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_i_q <= '0;
        acc_q_q <= '0;
        cnt_q   <= '0;
      end else begin
        acc_i_q <= acc_i_d;
        acc_q_q <= acc_q_d;
        cnt_q   <= cnt_d;
      end
    end

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, residual;
    logic [DW-1:0] head_q, head_d, push_data;
    logic          ovf_q, ovf_d;
    logic          pop, full, push_ok;

    assign push_data = {sum_q, sum_i};
    assign pop       = (count_q != '0) & axis_tready_i[c];
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign push_ok   = push_req & (~full | pop);
    assign count_d   = count_q + CW'(push_ok) - CW'(pop);
    assign residual  = count_q - CW'(pop);
    assign rd_ptr_d  = rd_ptr_q + AW'(pop);
    assign wr_ptr_d  = wr_ptr_q + AW'(push_ok);
    assign ovf_d     = ovf_q | (push_req & full & ~pop);

    // The next head comes from the incoming push when nothing older survives this edge.
    always_comb begin
      head_d = head_q;
      if (push_ok && residual == '0) begin
        head_d = push_data;
      end else if (count_d != '0) begin
        head_d = mem[rd_ptr_d];
      end
    end

    // NOTE: the storage array has no reset; pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
      if (push_ok) begin
        mem[wr_ptr_q] <= push_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        head_q   <= '0;
        ovf_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        head_q   <= head_d;
        ovf_q    <= ovf_d;
      end
    end

    assign axis_tdata_o[c*DW +: DW] = head_q;
    assign axis_tvalid_o[c]         = (count_q != '0);
    assign overflow_o[c]            = ovf_q;
  end

endmodule

// File: tb/tb_rx_chain_multi_model.sv
// Directed bench for rx_chain_multi_model: a per-channel scoreboard queue is filled as
// stimulus is driven and drained by a negedge monitor that compares every output beat.
module tb_rx_chain_multi_model;

  localparam int NCH = 2;
  localparam int IW  = 16;
  localparam int AWD = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [15:0]          rate_data;
  logic                 rate_valid;
  logic [NCH*2*IW-1:0]  dds_data;
  logic [NCH-1:0]       dds_valid;
  logic [NCH-1:0]       tready;
  logic [NCH*2*AWD-1:0] tdata;
  logic [NCH-1:0]       tvalid;
  logic [NCH-1:0]       overflow;

  int n_checks = 0;
  int n_errors = 0;
  int beats [NCH];
  logic [63:0] exp_q [NCH][$];

  rx_chain_multi_model dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .rate_axis_tdata_i    (rate_data),
    .rate_axis_tvalid_i   (rate_valid),
    .dds_iq_axis_tdata_i  (dds_data),
    .dds_iq_axis_tvalid_i (dds_valid),
    .axis_tready_i        (tready),
    .axis_tdata_o         (tdata),
    .axis_tvalid_o        (tvalid),
    .overflow_o           (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A beat transfers on the next rising edge whenever tvalid and tready are both high here.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst_n && tvalid[c] && tready[c]) begin
        beats[c]++;
        if (exp_q[c].size() == 0) begin
          n_checks++;
          n_errors++;
          $error("FAIL unexpected_beat ch%0d: observed %h expected none", c, tdata[c*64 +: 64]);
        end else begin
          chk($sformatf("beat_ch%0d", c), tdata[c*64 +: 64], exp_q[c].pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_rate(input logic [15:0] r);
    rate_data  = r;
    rate_valid = 1'b1;
    cyc();
    rate_valid = 1'b0;
  endtask

  // Drives one sample on channel c for one cycle; optionally records the expected beat.
  task automatic send(input int c, input int i, input int q, input bit expect_beat,
                      input int ei, input int eq);
    dds_data[c*32 +: 16]      = 16'(i);
    dds_data[c*32+16 +: 16]   = 16'(q);
    dds_valid[c]              = 1'b1;
    if (expect_beat) exp_q[c].push_back({32'(eq), 32'(ei)});
    cyc();
    dds_valid[c] = 1'b0;
  endtask

  initial begin
    int b0, b1;
    for (int c = 0; c < NCH; c++) beats[c] = 0;
    rst_n = 1'b0; rate_data = '0; rate_valid = 1'b0;
    dds_data = '0; dds_valid = '0; tready = '0;

    // Reset holds outputs at zero whatever the inputs do.
    repeat (4) begin
      rate_data  = 16'($urandom);
      rate_valid = 1'($urandom);
      dds_data   = {$urandom, $urandom};
      dds_valid  = 2'($urandom);
      tready     = 2'($urandom);
      cyc();
    end
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata_lo", tdata[63:0], 64'd0);
    chk("rst_tdata_hi", tdata[127:64], 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rate_valid = 1'b0; dds_valid = '0; tready = '0; dds_data = '0;
    #2 rst_n = 1'b1;
    repeat (5) cyc();
    chk("idle_tvalid", 64'(tvalid), 64'd0);

    // Basic decimation by 4 on channel 0.
    tready = 2'b11;
    write_rate(16'd4);
    send(0, 1, -1, 0, 0, 0);
    send(0, 2, -1, 0, 0, 0);
    send(0, 3, -1, 0, 0, 0);
    chk("basic_pre_tvalid", 64'(tvalid), 64'd0);
    send(0, 4, -1, 1, 10, -4);
    chk("basic_tvalid", 64'(tvalid), 64'b01);
    chk("basic_data", tdata[63:0], 64'hFFFFFFFC_0000000A);
    cyc();
    chk("basic_drained", 64'(tvalid), 64'd0);

    // Rate write discards partial sums and the sample valid in the same cycle.
    write_rate(16'd4);
    send(0, 7, 7, 0, 0, 0);
    send(0, 7, 7, 0, 0, 0);
    dds_data[15:0] = 16'd100; dds_valid[0] = 1'b1;
    write_rate(16'd2);
    dds_valid[0] = 1'b0;
    send(0, 5, 0, 0, 0, 0);
    send(0, 6, 0, 1, 11, 0);
    write_rate(16'd0);
    send(0, -3, 2, 1, -3, 2);
    send(0, 9, -9, 1, 9, -9);
    repeat (3) cyc();
    chk("rate_drained", 64'(tvalid), 64'd0);

    // Fill channel 0 past its depth under back-pressure.
    write_rate(16'd1);
    tready = 2'b00;
    for (int k = 1; k <= 9; k++) send(0, k, 0, k <= 8, k, 0);
    chk("ovf_tvalid", 64'(tvalid), 64'b01);
    chk("ovf_head", tdata[63:0], 64'd1);
    chk("ovf_flags", 64'(overflow), 64'b01);
    repeat (2) cyc();
    chk("ovf_head_stable", tdata[63:0], 64'd1);

    // Fill channel 1 exactly, then pop and push on the same edge.
    for (int k = 21; k <= 28; k++) send(1, k, 0, 1, k, 0);
    chk("full1_no_ovf", 64'(overflow), 64'b01);
    tready[1] = 1'b1;
    send(1, 30, 0, 1, 30, 0);
    tready[1] = 1'b0;
    chk("full_pop_no_ovf", 64'(overflow), 64'b01);
    chk("full_pop_head", tdata[127:64], 64'd22);

    b0 = beats[0]; b1 = beats[1];
    tready = 2'b11;
    repeat (12) cyc();
    chk("drain_beats_ch0", 64'(beats[0] - b0), 64'd8);
    chk("drain_beats_ch1", 64'(beats[1] - b1), 64'd8);
    chk("drain_tvalid", 64'(tvalid), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'b01);

    // Asynchronous reset with queued beats and a partial sum outstanding.
    write_rate(16'd2);
    tready = 2'b00;
    for (int k = 0; k < 7; k++) send(0, 1, 1, 0, 0, 0);
    chk("pre_rst_tvalid", 64'(tvalid), 64'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tvalid", 64'(tvalid), 64'd0);
    chk("async_overflow", 64'(overflow), 64'd0);
    #2 rst_n = 1'b1;
    tready = 2'b11;
    cyc();
    for (int k = 0; k < 9; k++) send(0, 1, 2, 0, 0, 0);
    chk("post_rst_rate10_pre", 64'(tvalid), 64'd0);
    send(0, 1, 2, 1, 10, 20);
    chk("post_rst_tvalid", 64'(tvalid), 64'b01);
    repeat (3) cyc();
    chk("sb_empty_ch0", 64'(exp_q[0].size()), 64'd0);
    chk("sb_empty_ch1", 64'(exp_q[1].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
